// File: rtl/pix_stream_tx.sv
// pix_stream_tx: streams a stored IMG_WIDTH x IMG_HEIGHT frame as a valid/sop/eop pixel stream.
// Define PIX_STREAM_TX_PING_PONG_EN for a double-buffered frame store (writes go to the back bank).
module pix_stream_tx #(
    parameter int PIX_WIDTH  = 16,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [PIX_WIDTH-1:0]  wr_data,
    input  logic                  start,
    input  logic                  i_ready,
    output logic [PIX_WIDTH-1:0]  o_data,
    output logic                  o_valid,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_drop
);
    localparam int NPIX = IMG_WIDTH*IMG_HEIGHT;
`ifdef PIX_STREAM_TX_PING_PONG_EN
    localparam int BANKS = 2;
`else
    localparam int BANKS = 1;
`endif
    localparam int DEPTH = BANKS*NPIX;
    localparam int PA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(NPIX+1);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

    state_t               state;
    logic [PIX_WIDTH-1:0] mem [DEPTH];
    logic [PIX_WIDTH-1:0] ram_q;
    logic [PIX_WIDTH-1:0] skid_data;
    logic                 rq_vld;
    logic                 skid_vld;
    logic [CW-1:0]        iss_cnt;
    logic [CW-1:0]        pix_cnt;
    logic [CW-1:0]        nxt_idx;
    logic                 bank_sel;
    logic                 wr_bank;
    logic                 wr_oob;
    logic                 wr_ok;
    logic                 start_acc;
    logic                 xfer;
    logic                 issue;
    logic                 have_next;
    logic [1:0]           occ;
    logic [PA_W-1:0]      wr_pa;
    logic [PA_W-1:0]      rd_pa;

    assign wr_oob = int'(wr_addr) >= NPIX;
`ifdef PIX_STREAM_TX_PING_PONG_EN
    assign wr_ok   = wr_en && !wr_oob;
    assign wr_bank = ~bank_sel;
`else
    assign wr_ok   = wr_en && !wr_oob && !busy;
    assign wr_bank = 1'b0;
`endif
    assign wr_pa = PA_W'(int'(wr_bank) * NPIX + int'(wr_addr));
    assign rd_pa = PA_W'(int'(bank_sel) * NPIX + int'(iss_cnt));

    assign start_acc = start && (state == IDLE);
    assign xfer      = o_valid && i_ready;
    assign nxt_idx   = pix_cnt + CW'(xfer);
    assign have_next = skid_vld || rq_vld;

    // Words held after this edge (output, skid, RAM register). A read is issued only if the
    // word landing next cycle is guaranteed a slot in the output or skid register.
    assign occ   = 2'(o_valid) + 2'(skid_vld) + 2'(rq_vld) - 2'(xfer);
    assign issue = (state == FETCH || state == STREAM) && (iss_cnt != CW'(NPIX)) && (occ < 2'd2);

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (wr_ok) mem[wr_pa] <= wr_data;
            if (issue) ram_q <= mem[rd_pa];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_sop     <= 1'b0;
            o_eop     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_drop   <= 1'b0;
            rq_vld    <= 1'b0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
            iss_cnt   <= '0;
            pix_cnt   <= '0;
            bank_sel  <= 1'b0;
        end else if (clk_en) begin
            done    <= 1'b0;
            wr_drop <= (wr_drop && !start_acc) || (wr_en && !wr_ok);
            rq_vld  <= issue;
            pix_cnt <= nxt_idx;
            if (issue) iss_cnt <= iss_cnt + 1'b1;

            if (!o_valid || xfer) begin
                o_valid <= have_next;
                o_sop   <= have_next && (nxt_idx == '0);
                o_eop   <= have_next && (nxt_idx == CW'(NPIX-1));
                if (skid_vld) begin
                    o_data    <= skid_data;
                    skid_vld  <= rq_vld;
                    skid_data <= ram_q;
                end else if (rq_vld) begin
                    o_data <= ram_q;
                end
            end else if (rq_vld) begin
                skid_vld  <= 1'b1;
                skid_data <= ram_q;
            end

            case (state)
                IDLE: if (start_acc) begin
                    state   <= FETCH;
                    busy    <= 1'b1;
                    iss_cnt <= '0;
                    pix_cnt <= '0;
`ifdef PIX_STREAM_TX_PING_PONG_EN
                    bank_sel <= ~bank_sel;
`endif
                end
                FETCH: state <= STREAM;
                STREAM: if (xfer && o_eop) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pix_stream_tx.sv
// Scoreboard bench for pix_stream_tx on a 4x3 frame: stimulus pushes expected pixels, a negedge monitor pops them.
module tb_pix_stream_tx;
    localparam int PW = 16;
    localparam int IW = 4;
    localparam int IH = 3;
    localparam int NP = IW*IH;
    localparam int AW = $clog2(NP);
`ifdef PIX_STREAM_TX_PING_PONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [PW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          i_ready = 1'b1;
    logic [PW-1:0] o_data;
    logic          o_valid, o_sop, o_eop, busy, done, wr_drop;

    pix_stream_tx #(.PIX_WIDTH(PW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid),
        .o_sop(o_sop), .o_eop(o_eop), .busy(busy), .done(done), .wr_drop(wr_drop)
    );

    typedef struct {
        logic [PW-1:0] d;
        logic          sop;
        logic          eop;
    } exp_t;

    exp_t          q[$];
    logic [PW-1:0] mem_m [2][NP];
    int            bsel_m = 0;
    bit            exp_drop = 1'b0;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            xfer_cnt = 0;
    int            rmode = 0;
    bit            first_seen = 1'b1;
    bit            lat_chk = 1'b1;
    bit            done_exp = 1'b0;
    bit            stall_prev = 1'b0;
    logic [PW-1:0] hd;
    logic          hs, he;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // i_ready / clk_en pattern generator: 0 steady, 1 = 1,0,0,1 repeating, 2 random ready, 3 random ready+enable
    initial begin
        int pat = 0;
        forever begin
            @(posedge clk);
            #1;
            pat++;
            case (rmode)
                0: begin i_ready = 1'b1; clk_en = 1'b1; end
                1: begin i_ready = (pat % 4 == 0) || (pat % 4 == 3); clk_en = 1'b1; end
                2: begin i_ready = 1'($urandom_range(0, 1)); clk_en = 1'b1; end
                default: begin
                    i_ready = 1'($urandom_range(0, 1));
                    clk_en  = ($urandom_range(0, 3) != 0);
                end
            endcase
        end
    end

    task automatic wr_word(input int a, input logic [PW-1:0] d, input bit bsy);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a < NP && (PP || !bsy)) mem_m[PP ? 1 - bsel_m : 0][a] = d;
        else exp_drop = 1'b1;
    endtask

    task automatic load_frame(input bit rnd, input bit bsy);
        for (int a = 0; a < NP; a++) wr_word(a, rnd ? PW'($urandom) : PW'(a * 3), bsy);
    endtask

    task automatic start_frame();
        int bk;
        if (PP) bsel_m = 1 - bsel_m;
        bk = PP ? bsel_m : 0;
        for (int i = 0; i < NP; i++) q.push_back('{d: mem_m[bk][i], sop: (i == 0), eop: (i == NP - 1)});
        exp_drop = 1'b0;
        xfer_cnt = 0;
        lat_chk = 1'b1;
        first_seen = 1'b0;
        start = 1'b1;
        start_cyc = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        rmode = 0;
        repeat (3) tick();
        chk("queue_drained", q.size(), 0);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic wait_px(input int k);
        int n = 0;
        while (xfer_cnt < k && n < 200) begin
            tick();
            n++;
        end
        chk("reach_pixel", 32'(xfer_cnt >= k), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            bit xf;
            bit nd;
            exp_t e;
            chk("done", 32'(done), 32'(done_exp));
            if (o_valid && !first_seen) begin
                if (lat_chk) chk("first_valid_latency", cyc - start_cyc, 2);
                first_seen = 1'b1;
            end
            if (stall_prev) begin
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_data", 32'(o_data), 32'(hd));
                chk("stall_sop", 32'(o_sop), 32'(hs));
                chk("stall_eop", 32'(o_eop), 32'(he));
            end
            xf = o_valid && i_ready && clk_en;
            nd = clk_en ? 1'b0 : done_exp;
            if (xf) begin
                if (q.size() == 0) begin
                    chk("extra_pixel", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    chk("pix_data", 32'(o_data), 32'(e.d));
                    chk("pix_sop", 32'(o_sop), 32'(e.sop));
                    chk("pix_eop", 32'(o_eop), 32'(e.eop));
                    xfer_cnt++;
                    if (e.eop) nd = 1'b1;
                end
            end
            done_exp = nd;
            stall_prev = o_valid && !xf;
            hd = o_data;
            hs = o_sop;
            he = o_eop;
        end
    end

    initial begin
        repeat (2) tick();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_sop", 32'(o_sop), 32'd0);
        chk("rst_eop", 32'(o_eop), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_drop", 32'(wr_drop), 32'd0);
        rst_n = 1'b1;
        tick();

        // full-rate frame, then 1,0,0,1 back-pressure
        load_frame(1'b0, 1'b0);
        start_frame();
        wait_done();
        load_frame(1'b0, 1'b0);
        rmode = 1;
        start_frame();
        wait_done();

        // start pulsed mid-frame is ignored
        load_frame(1'b0, 1'b0);
        start_frame();
        wait_px(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_mid_frame", 32'(busy), 32'd1);
        wait_done();

        // reset mid-frame, then replay from pixel 0
        load_frame(1'b0, 1'b0);
        start_frame();
        wait_px(7);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_sop", 32'(o_sop), 32'd0);
        chk("arst_eop", 32'(o_eop), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        q.delete();
        done_exp = 1'b0;
        stall_prev = 1'b0;
        first_seen = 1'b1;
        exp_drop = 1'b0;
        if (PP) bsel_m = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("no_done_after_rst", 32'(done), 32'd0);
        load_frame(1'b0, 1'b0);
        start_frame();
        wait_done();

        // out-of-range write, writes while streaming, start clears the flag
        load_frame(1'b1, 1'b0);
        wr_word(NP + $urandom_range(0, (1 << AW) - NP - 1), 16'hdead, 1'b0);
        chk("drop_oob", 32'(wr_drop), 32'(exp_drop));
        rmode = 1;
        start_frame();
        chk("drop_cleared", 32'(wr_drop), 32'(exp_drop));
        load_frame(1'b1, 1'b1);
        chk("drop_busy_write", 32'(wr_drop), 32'(exp_drop));
        wait_done();
        chk("drop_sticky", 32'(wr_drop), 32'(exp_drop));
        start_frame();
        chk("drop_cleared2", 32'(wr_drop), 32'd0);
        wait_done();

        // random data with random ready, then random ready and clock enable
        for (int f = 0; f < 4; f++) begin
            load_frame(1'b1, 1'b0);
            start_frame();
            rmode = (f < 2) ? 2 : 3;
            if (rmode == 3) lat_chk = 1'b0;
            wait_done();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
